// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every signal of the shared memory-port arbiter except clock/reset.
//
//   Fetch side  : if_req, if_addr        -> if_ack, if_rdata
//   Data side   : dm_req, dm_we, dm_addr, dm_wdata -> dm_ack, dm_rdata
//   Memory side : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ready
//   Status      : err, stall, perf_if_cnt, perf_dm_cnt, perf_conf_cnt
//
//   Modports
//     slave  : the arbiter itself (serves both pipeline stages, drives memory)
//     master : the environment (pipeline requesters and the memory device)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic        err;
  logic        stall;
  logic [15:0] perf_if_cnt;
  logic [15:0] perf_dm_cnt;
  logic [15:0] perf_conf_cnt;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           err, stall, perf_if_cnt, perf_dm_cnt, perf_conf_cnt
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           err, stall, perf_if_cnt, perf_dm_cnt, perf_conf_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one 16-bit memory port between the fetch stage and the mem stage.
//   Data requests win conflicts, but after STARVE_MAX consecutive data grants
//   with a fetch waiting, the fetch is forced through. An access that sees no
//   mem_ready for TIMEOUT cycles is aborted and acked with rdata 16'hFFFF and
//   err=1. Every transaction is IDLE -> ACCESS (1+ cycles) -> RESP.
//
//   Ports
//     clock : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : mem_port_arbiter_if.slave (requests, acks, memory port, status)
//
//   Parameters
//     STARVE_MAX : data grants tolerated while fetch waits (1..15)
//     TIMEOUT    : ACCESS cycles without mem_ready before abort (1..255)
//
//   Build option
//     MEM_PORT_ARBITER_PERF_EN : when defined, builds saturating grant and
//     conflict counters; otherwise the perf outputs are tied to zero.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 255
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  // The counter holds the number of already-missed cycles, so the current
  // miss is the TIMEOUT-th one when it equals TIMEOUT-1.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        grant;       // a new transaction is accepted this cycle
  logic        grant_dm;    // ... and it belongs to the data side
  logic        tmo_hit;     // this ACCESS cycle exhausts the wait budget
  logic        owner_dm;
  logic        timed_out;
  logic [3:0]  starve_cnt;
  logic [7:0]  tmo_cnt;
  logic [15:0] resp_data;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dm  = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          grant     = 1'b1;
          grant_dm  = bus.dm_req && !(bus.if_req && starve_cnt == STARVE_LIM);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          state_nxt = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign resp_data = bus.mem_ready ? bus.mem_rdata : 16'hFFFF;

  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_dm      <= 1'b0;
      timed_out     <= 1'b0;
      starve_cnt    <= '0;
      tmo_cnt       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
    end else begin
      if (grant) begin
        owner_dm      <= grant_dm;
        timed_out     <= 1'b0;
        tmo_cnt       <= '0;
        bus.mem_addr  <= grant_dm ? bus.dm_addr : bus.if_addr;
        bus.mem_we    <= grant_dm && bus.dm_we;
        bus.mem_wdata <= (grant_dm && bus.dm_we) ? bus.dm_wdata : 16'h0000;
        // Only data grants that overtake a waiting fetch count as starvation.
        if (!grant_dm)
          starve_cnt <= '0;
        else if (bus.if_req && starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == ACCESS) begin
        if (state_nxt == RESP) begin
          if (owner_dm) bus.dm_rdata <= resp_data;
          else          bus.if_rdata <= resp_data;
          timed_out <= tmo_hit;
        end else begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
      end
    end
  end

  // Strobes decode straight from registered state, so they are glitch-free
  // and the ack lasts exactly the single RESP cycle.
  assign bus.mem_en = (state == ACCESS);
  assign bus.if_ack = (state == RESP) && !owner_dm;
  assign bus.dm_ack = (state == RESP) &&  owner_dm;
  assign bus.err    = (state == RESP) &&  timed_out;
  assign bus.stall  = (bus.if_req && !bus.if_ack) || (bus.dm_req && !bus.dm_ack);

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] perf_if, perf_dm, perf_conf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_if   <= '0;
      perf_dm   <= '0;
      perf_conf <= '0;
    end else begin
      if (grant && !grant_dm && perf_if != 16'hFFFF) perf_if <= perf_if + 16'd1;
      if (grant &&  grant_dm && perf_dm != 16'hFFFF) perf_dm <= perf_dm + 16'd1;
      if (state == IDLE && bus.if_req && bus.dm_req && perf_conf != 16'hFFFF)
        perf_conf <= perf_conf + 16'd1;
    end
  end

  assign bus.perf_if_cnt   = perf_if;
  assign bus.perf_dm_cnt   = perf_dm;
  assign bus.perf_conf_cnt = perf_conf;
`else
  assign bus.perf_if_cnt   = 16'h0000;
  assign bus.perf_dm_cnt   = 16'h0000;
  assign bus.perf_conf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized request traffic for
//   mem_port_arbiter. Expected grants, bus values, latencies, ack data and
//   counters come from a transaction-level model: a priority/starvation rule
//   on integers, a sparse memory image and simple grant tallies. Honours
//   MEM_PORT_ARBITER_PERF_EN for the perf counter expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 255;

`ifdef MEM_PORT_ARBITER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          m_if     = 0;
  int          m_dm     = 0;
  int          m_conf   = 0;
  int          m_starve = 0;
  logic [15:0] mem_model [logic [15:0]];

  function automatic logic [15:0] mem_read(logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] perf_exp(int n);
    logic [15:0] v;
    v = (n > 65535) ? 16'hFFFF : 16'(n);
    return PERF ? v : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_perf(input string tag);
    check({tag, "_perf_if"},   bus.perf_if_cnt,   perf_exp(m_if));
    check({tag, "_perf_dm"},   bus.perf_dm_cnt,   perf_exp(m_dm));
    check({tag, "_perf_conf"}, bus.perf_conf_cnt, perf_exp(m_conf));
  endtask

  task automatic model_reset();
    m_if = 0; m_dm = 0; m_conf = 0; m_starve = 0;
  endtask

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0700 + 16'($urandom_range(0, 7));
  endtask

  task automatic new_dm();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'($urandom);
    bus.dm_addr  = 16'h0700 + 16'($urandom_range(0, 7));
    bus.dm_wdata = 16'($urandom);
  endtask

  // Entered in an IDLE cycle with at least one request driven; returns in the
  // RESP cycle of the granted transaction. waits >= TIMEOUT means the memory
  // never answers.
  task automatic run_txn(input int waits, output bit dm);
    logic [15:0] a, wd, rsp, rd;
    bit          we, tmo, stall_exp;
    int          n_acc;
    #1;
    // mem_ready outside ACCESS must be ignored.
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    check_bit("idle_mem_en", bus.mem_en, 1'b0);
    check_bit("idle_if_ack", bus.if_ack, 1'b0);
    check_bit("idle_dm_ack", bus.dm_ack, 1'b0);
    check_bit("idle_stall",  bus.stall,  1'b1);

    if (bus.if_req && bus.dm_req) begin
      m_conf++;
      dm = (m_starve < STARVE_MAX);
    end else begin
      dm = bus.dm_req;
    end
    if (dm) begin
      m_dm++;
      if (bus.if_req && m_starve < STARVE_MAX) m_starve++;
    end else begin
      m_if++;
      m_starve = 0;
    end

    a     = dm ? bus.dm_addr : bus.if_addr;
    we    = dm && bus.dm_we;
    wd    = we ? bus.dm_wdata : 16'h0000;
    tmo   = (waits >= TIMEOUT);
    n_acc = tmo ? TIMEOUT : waits + 1;
    rsp   = mem_read(a);
    rd    = tmo ? 16'hFFFF : rsp;

    for (int k = 0; k < n_acc; k++) begin
      tick();
      check_bit("acc_mem_en",    bus.mem_en, 1'b1);
      check_bit("acc_mem_we",    bus.mem_we, we);
      check    ("acc_mem_addr",  bus.mem_addr, a);
      check    ("acc_mem_wdata", bus.mem_wdata, wd);
      check_bit("acc_no_ack",    bus.if_ack | bus.dm_ack, 1'b0);
      check_bit("acc_stall",     bus.stall, 1'b1);
      if (!tmo && k == waits) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rsp;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end
    end

    tick();
    bus.mem_ready = 1'b0;
    check_bit("resp_mem_en", bus.mem_en, 1'b0);
    check_bit("resp_if_ack", bus.if_ack, !dm);
    check_bit("resp_dm_ack", bus.dm_ack, dm);
    check_bit("resp_err",    bus.err, tmo);
    if (dm) check("resp_dm_rdata", bus.dm_rdata, rd);
    else    check("resp_if_rdata", bus.if_rdata, rd);
    stall_exp = (bus.if_req && dm) || (bus.dm_req && !dm);
    check_bit("resp_stall", bus.stall, stall_exp);
    check_perf("resp");
    if (we && !tmo) mem_model[a] = wd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit o;
    int idle_n;
    bit pat [8];
    bit t6_if [9];
    bit t6_dm [9];
    pat   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t6_if = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t6_dm = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tick();
    tick();

    // Reset state.
    check_bit("rst_mem_en",   bus.mem_en, 1'b0);
    check_bit("rst_mem_we",   bus.mem_we, 1'b0);
    check_bit("rst_if_ack",   bus.if_ack, 1'b0);
    check_bit("rst_dm_ack",   bus.dm_ack, 1'b0);
    check_bit("rst_err",      bus.err, 1'b0);
    check_bit("rst_stall",    bus.stall, 1'b0);
    check    ("rst_mem_addr", bus.mem_addr, 16'h0000);
    check    ("rst_wdata",    bus.mem_wdata, 16'h0000);
    check    ("rst_if_rdata", bus.if_rdata, 16'h0000);
    check    ("rst_dm_rdata", bus.dm_rdata, 16'h0000);
    check_perf("rst");
    reset = 1'b1;
    tick();

    // Fetch, zero wait states.
    mem_model[16'h0010] = 16'h1234;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    run_txn(0, o);
    check_bit("t1_owner", o, 1'b0);
    check("t1_if_rdata", bus.if_rdata, 16'h1234);
    bus.if_req = 1'b0;
    tick();

    // Store with two wait states, then read it back.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 16'h0100; bus.dm_wdata = 16'hBEEF;
    run_txn(2, o);
    check_bit("t2_owner", o, 1'b1);
    bus.dm_we = 1'b0;
    tick();
    run_txn(0, o);
    check("t2_readback", bus.dm_rdata, 16'hBEEF);
    bus.dm_req = 1'b0;
    tick();

    // Both requesting continuously: starvation guard shapes the grant order.
    bus.if_req = 1'b1; bus.if_addr = 16'h0300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0400;
    for (int i = 0; i < 8; i++) begin
      run_txn(0, o);
      check_bit("t3_order", o, pat[i]);
      if (o) bus.dm_addr = bus.dm_addr + 16'd1;
      else   bus.if_addr = bus.if_addr + 16'd1;
      if (i == 7) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
      tick();
    end

    // Memory never answers: timeout abort, then a normal fetch.
    bus.if_req = 1'b1; bus.if_addr = 16'h0500;
    run_txn(TIMEOUT, o);
    check("t4_if_rdata", bus.if_rdata, 16'hFFFF);
    check_bit("t4_err", bus.err, 1'b1);
    bus.if_addr = 16'h0501;
    tick();
    run_txn(1, o);
    check_bit("t4_err_clear", bus.err, 1'b0);
    bus.if_req = 1'b0;
    tick();

    // Reset in the second ACCESS cycle of a load.
    mem_model[16'h0600] = 16'hCAFE;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 16'h0600;
    tick();
    check_bit("t5_acc1_en", bus.mem_en, 1'b1);
    bus.mem_ready = 1'b0;
    tick();
    check_bit("t5_acc2_en", bus.mem_en, 1'b1);
    reset = 1'b0;
    tick();
    check_bit("t5_rst_en",     bus.mem_en, 1'b0);
    check_bit("t5_rst_dm_ack", bus.dm_ack, 1'b0);
    check_bit("t5_rst_if_ack", bus.if_ack, 1'b0);
    check_bit("t5_rst_err",    bus.err, 1'b0);
    check    ("t5_rst_addr",   bus.mem_addr, 16'h0000);
    check    ("t5_rst_rdata",  bus.dm_rdata, 16'h0000);
    reset = 1'b1;
    model_reset();
    check_perf("t5_rst");
    run_txn(1, o);
    check_bit("t5_owner", o, 1'b1);
    check("t5_dm_rdata", bus.dm_rdata, 16'hCAFE);
    bus.dm_req = 1'b0;
    tick();

    // Counter scenario: 5 fetch grants, 4 data grants, 2 conflict cycles.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 9; i++) begin
      bus.if_req = t6_if[i];
      if (t6_dm[i]) new_dm();
      else          bus.dm_req = 1'b0;
      if (t6_if[i]) bus.if_addr = 16'h0800 + 16'(i);
      run_txn(0, o);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();
    end
    check("t6_perf_if",   bus.perf_if_cnt,   PERF ? 16'd5 : 16'd0);
    check("t6_perf_dm",   bus.perf_dm_cnt,   PERF ? 16'd4 : 16'd0);
    check("t6_perf_conf", bus.perf_conf_cnt, PERF ? 16'd2 : 16'd0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if (!bus.if_req && !bus.dm_req) begin
        idle_n = int'($urandom_range(0, 2));
        for (int j = 0; j < idle_n; j++) begin
          check_bit("quiet_mem_en", bus.mem_en, 1'b0);
          check_bit("quiet_stall",  bus.stall, 1'b0);
          tick();
        end
        case ($urandom_range(0, 2))
          0:       new_if();
          1:       new_dm();
          default: begin new_if(); new_dm(); end
        endcase
      end
      run_txn(int'($urandom_range(0, 3)), o);
      if (o) begin
        if ($urandom_range(0, 3) != 0) new_dm();
        else bus.dm_req = 1'b0;
      end else begin
        if ($urandom_range(0, 3) != 0) new_if();
        else bus.if_req = 1'b0;
      end
      if (!bus.if_req && $urandom_range(0, 1) == 1) new_if();
      if (!bus.dm_req && $urandom_range(0, 1) == 1) new_dm();
      tick();
    end

    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
    check_perf("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single shared 16-bit memory port between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the 5-stage pipeline.
- Uses a level request / one-cycle acknowledge handshake on each side and drives the memory port through a 3-state FSM.
- Data requests have priority; an anti-starvation counter guarantees fetch progress.
- Adds a wait-state timeout and emits a pipeline stall hint.

Parameters:
STARVE_MAX, 3, maximum consecutive data grants while a fetch is pending before fetch is forced (1..15).
TIMEOUT, 255, maximum ACCESS-state cycles without mem_ready before the access is aborted (1..255).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
if_req  in  1  fetch read request; held until if_ack.
if_addr  in  16  fetch address.
if_ack  out  1  one-cycle completion pulse to fetch.
if_rdata  out  16  instruction word; valid while if_ack=1.
dm_req  in  1  data request; held until dm_ack.
dm_we  in  1  1=store, 0=load.
dm_addr  in  16  data address.
dm_wdata  in  16  store data.
dm_ack  out  1  one-cycle completion pulse to mem stage.
dm_rdata  out  16  load data; valid while dm_ack=1.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  16  memory address.
mem_wdata  out  16  memory write data.
mem_rdata  in  16  memory read data; valid with mem_ready.
mem_ready  in  1  memory completion; sampled only while mem_en=1.
err  out  1  one-cycle pulse coincident with an ack whose access timed out.
stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
perf_if_cnt  out  16  fetch grants (see Optional Feature).
perf_dm_cnt  out  16  data grants.
perf_conf_cnt  out  16  cycles in IDLE with both requests high.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State goes to IDLE.
  - mem_en, mem_we, if_ack, dm_ack and err go to 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata, the starvation counter, the timeout counter and the perf counters go to 0.
  - A reset during ACCESS or RESP aborts the transaction with no ack; the requester keeps its request high and is re-served after reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE, mem_en=0.
  - Any request: select the owner, register mem_addr/mem_we/mem_wdata from the owner's inputs, clear the timeout counter, go to ACCESS.
  - mem_we=0 for fetch; mem_wdata is don't-care for loads and is driven 0.
- Priority:
  - Only one request high: grant it.
  - Both high: grant dm, unless starve_cnt==STARVE_MAX, in which case grant fetch.
  - starve_cnt increments (saturating at STARVE_MAX) on every dm grant made while if_req=1.
  - starve_cnt clears on every fetch grant.
- ACCESS:
  - mem_en=1; address, data and we are held stable.
  - mem_ready=1: capture mem_rdata into the owner's rdata register, go to RESP.
  - Otherwise: increment the timeout counter. When the counter reaches TIMEOUT, load the owner's rdata with 16'hFFFF, set the error flag, go to RESP.
- RESP:
  - mem_en=0.
  - The owner's ack=1 for exactly this cycle; err=1 if the access timed out.
  - Always return to IDLE next cycle.
  - The requester samples the ack at the closing edge and drops or changes its request, so a re-sampled request in IDLE is always a new transaction.
- Latency with zero wait states (mem_ready in the first ACCESS cycle): request sampled in IDLE at cycle N, mem_en high in cycle N+1, ack in cycle N+2. Each wait state adds one cycle.
- Throughput: a new grant at most every 3 cycles.
- Acks are mutually exclusive; if_ack and dm_ack are never high together.
- mem_ready while mem_en=0 is ignored.
- A request that drops before its ack is not supported; the transaction still completes and acks.
- The timeout counter is 8 bits.

Optional Feature:
Macro MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - perf_if_cnt increments on each fetch grant.
  - perf_dm_cnt increments on each data grant.
  - perf_conf_cnt increments each IDLE cycle with if_req & dm_req.
  - All three are 16-bit saturating at 16'hFFFF and cleared by reset.
- Undefined: counter logic is not built and all three outputs are tied to 16'h0000. Ports are present in both builds.

Test Plan:
- Fetch only, if_addr=16'h0010, mem_ready returned in the first ACCESS cycle with mem_rdata=16'h1234 -> mem_en high 1 cycle, mem_we=0; if_ack pulse in cycle N+2 with if_rdata=16'h1234; stall high N..N+1.
- Store dm_addr=16'h0100, dm_wdata=16'hBEEF, 2 wait states -> mem_we=1, mem_addr=16'h0100 and mem_wdata=16'hBEEF held for 3 ACCESS cycles; dm_ack in cycle N+4.
- Both requesting continuously, STARVE_MAX=3 -> grant order dm, dm, dm, if, dm, dm, dm, if; no simultaneous acks.
- mem_ready never asserted, TIMEOUT=255 -> after 255 ACCESS cycles, one RESP cycle with if_ack=1, err=1, if_rdata=16'hFFFF; next request is served normally.
- reset=0 in the 2nd ACCESS cycle of a load -> next cycle IDLE, mem_en=0, no dm_ack; after reset releases, the held dm_req completes with the correct data.
- With MEM_PORT_ARBITER_PERF_EN: 5 fetch grants, 4 data grants, 2 conflict cycles -> counters read 5/4/2; without the macro all read 0.
